// File: rtl/bin_to_bcd_converter.sv
// Purpose : sequential double-dabble binary-to-BCD converter feeding a 4-digit display mux.
// Latency : START accepted at edge k -> digits/DONE at edge k+IN_WIDTH+1 (hex bypass: k+1).
// Backpres: START is only sampled in IDLE; requests while BUSY are dropped. Option macro: BIN_TO_BCD_HEX_BYPASS_EN.
module bin_to_bcd_converter #(
  parameter int IN_WIDTH  = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
`ifdef BIN_TO_BCD_HEX_BYPASS_EN
  input  logic                HEX_MODE,
`endif
  input  logic [IN_WIDTH-1:0] VALUE,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVF,
  output logic [3:0]          DIGIT1,
  output logic [3:0]          DIGIT2,
  output logic [3:0]          DIGIT3,
  output logic [3:0]          DIGIT4
);

  // Shift register holds four BCD nibbles above the binary operand.
  localparam int SW = IN_WIDTH + 16;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_adj;
  logic [CW-1:0]   cnt;
  logic            hex_q;
  logic            hex_req;
  logic            value_ovf;
  logic [15:0]     bcd_val;
  logic [15:0]     hex_val;

`ifdef BIN_TO_BCD_HEX_BYPASS_EN
  assign hex_req = HEX_MODE;
`else
  assign hex_req = 1'b0;
`endif

  assign value_ovf = (32'(VALUE) > 32'(MAX_VALUE));
  assign bcd_val   = sr[SW-1 -: 16];
  // In hex mode the operand is still sitting untouched in the low bits.
  assign hex_val   = 16'(sr[IN_WIDTH-1:0]);
  assign BUSY      = (state != S_IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: the SHIFT phase ends on the edge where the counter hits zero.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = hex_req ? S_LOAD : S_SHIFT;
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[IN_WIDTH + 4*i +: 4] >= 4'd5)
        sr_adj[IN_WIDTH + 4*i +: 4] = sr[IN_WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  // Datapath: capture, iterate, then publish digits with a one-cycle DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sr     <= '0;
      cnt    <= '0;
      hex_q  <= 1'b0;
      OVF    <= 1'b0;
      DONE   <= 1'b0;
      DIGIT1 <= 4'd0;
      DIGIT2 <= 4'd0;
      DIGIT3 <= 4'd0;
      DIGIT4 <= 4'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            sr    <= {16'b0, VALUE};
            cnt   <= CW'(IN_WIDTH);
            hex_q <= hex_req;
            OVF   <= hex_req ? 1'b0 : value_ovf;
          end
        end
        S_SHIFT: begin
          sr  <= {sr_adj[SW-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        S_LOAD: begin
          DONE <= 1'b1;
          if (hex_q) begin
            {DIGIT1, DIGIT2, DIGIT3, DIGIT4} <= hex_val;
          end else if (OVF) begin
            // Out-of-range input saturates the display at 9999.
            {DIGIT1, DIGIT2, DIGIT3, DIGIT4} <= 16'h9999;
          end else begin
            {DIGIT1, DIGIT2, DIGIT3, DIGIT4} <= bcd_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Testbench for bin_to_bcd_converter: directed cases plus randomized START/VALUE traffic,
// scored against an arithmetic reference (div/mod by powers of ten, saturation at MAX_VALUE).
module tb_bin_to_bcd_converter;

  localparam int IN_WIDTH  = 14;
  localparam int MAX_VALUE = 9999;
  localparam int LAT       = IN_WIDTH + 1;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic                START;
  logic [IN_WIDTH-1:0] VALUE;
`ifdef BIN_TO_BCD_HEX_BYPASS_EN
  logic                HEX_MODE = 1'b0;
`endif
  logic                BUSY, DONE, OVF;
  logic [3:0]          DIGIT1, DIGIT2, DIGIT3, DIGIT4;

  bin_to_bcd_converter #(.IN_WIDTH(IN_WIDTH), .MAX_VALUE(MAX_VALUE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
`ifdef BIN_TO_BCD_HEX_BYPASS_EN
    .HEX_MODE(HEX_MODE),
`endif
    .VALUE(VALUE), .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
    .DIGIT1(DIGIT1), .DIGIT2(DIGIT2), .DIGIT3(DIGIT3), .DIGIT4(DIGIT4)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [15:0] digits;
    logic        ovf;
    int          done_edge;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          busy_end;
  bit          pend_vld;
  bit          done_exp;
  logic [15:0] pend_digits;
  logic [15:0] held_digits;
  logic        ovf_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] ref_digits(input int v);
    int s;
    s = (v > MAX_VALUE) ? MAX_VALUE : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Reference model: counts edges, decides acceptance, predicts result and timing.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc = 0; busy_end = 0; pend_vld = 0; done_exp = 0;
      held_digits = 16'h0; ovf_m = 1'b0; sb.delete();
    end else begin
      cyc++;
      done_exp = 0;
      if (pend_vld && cyc == busy_end) begin
        done_exp    = 1;
        held_digits = pend_digits;
        pend_vld    = 0;
      end else if (START && cyc > busy_end) begin
        pend_digits = ref_digits(int'(VALUE));
        ovf_m       = (int'(VALUE) > MAX_VALUE);
        busy_end    = cyc + LAT;
        pend_vld    = 1;
        sb.push_back('{pend_digits, ovf_m, busy_end});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: samples away from the rising edge, pops the scoreboard on DONE.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or negedge RESET_N);
      #1;
      if (!RESET_N) begin
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_digits", 32'({DIGIT1, DIGIT2, DIGIT3, DIGIT4}), 32'h0);
      end else begin
        chk("busy", 32'(BUSY), 32'(cyc < busy_end));
        chk("done", 32'(DONE), 32'(done_exp));
        chk("ovf", 32'(OVF), 32'(ovf_m));
        chk("held_digits", 32'({DIGIT1, DIGIT2, DIGIT3, DIGIT4}), 32'(held_digits));
        if (DONE) begin
          chk("sb_depth", 32'(sb.size()), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_digits", 32'({DIGIT1, DIGIT2, DIGIT3, DIGIT4}), 32'(e.digits));
            chk("sb_ovf", 32'(OVF), 32'(e.ovf));
            chk("sb_latency", 32'(cyc), 32'(e.done_edge));
          end
        end
        if (sb.size() > 0)
          chk("done_missing", 32'(cyc <= sb[0].done_edge), 32'd1);
      end
    end
  end

  task automatic pulse(input int v);
    VALUE = IN_WIDTH'(v);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Stimulus.
  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    VALUE   = '0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    idle(3);

    pulse(1234); idle(20);

    // START held high across two results: 9999 then 0.
    VALUE = IN_WIDTH'(9999);
    START = 1'b1;
    @(posedge CLK); #1;
    VALUE = '0;
    idle(20);
    START = 1'b0;
    idle(20);

    pulse(12000); idle(20);
    pulse(7);     idle(20);
    pulse(10000); idle(20);
    pulse(16383); idle(20);

    // Request during BUSY must be ignored.
    pulse(4321);
    idle(3);
    pulse(5555);
    idle(20);

    // Reset mid-conversion: no DONE, outputs cleared without a clock edge.
    pulse(6789);
    repeat (4) @(posedge CLK);
    #4 RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    idle(20);

    // Random traffic: VALUE wiggles every cycle so in-flight capture is exercised.
    for (int i = 0; i < 1500; i++) begin
      START = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) VALUE = IN_WIDTH'($urandom_range(10000, 16383));
      else                           VALUE = IN_WIDTH'($urandom_range(0, 9999));
      @(posedge CLK); #1;
    end
    START = 1'b0;
    idle(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
